// File: rtl/bcd_pkg.sv
// Shared constants for the binary-to-BCD converter and its add-3 cells.
package bcd_pkg;

  localparam int          BCD_DIGIT_W     = 4;
  localparam int          BCD_DIGITS      = 3;
  localparam logic [3:0]  BCD_BLANK       = 4'hF;
  localparam logic [3:0]  BCD_ADD3_THRESH = 4'd5;

endpackage : bcd_pkg

// File: rtl/bcd_add3.sv
// One double-dabble correction cell: a BCD nibble of 5 or more gets +3 before the shift.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  // Add-3 correction so the following left shift carries correctly into the next digit.
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= BCD_ADD3_THRESH) begin
      digit_o = digit_i + 4'd3;
    end else begin
      digit_o = digit_i;
    end
  end

endmodule : bcd_add3

// File: rtl/binary_to_bcd.sv
// Registered binary-to-3-digit-BCD converter (combinational double dabble, one cycle latency).
// Optional leading-zero blanking is enabled by defining BCD_BLANK_LEADING_ZERO_EN.
module binary_to_bcd
  import bcd_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       signal,
  output logic [BCD_DIGIT_W-1:0] hundred,
  output logic [BCD_DIGIT_W-1:0] tens,
  output logic [BCD_DIGIT_W-1:0] ones
);

  localparam int BCD_W = BCD_DIGIT_W * BCD_DIGITS;

  // bcd_s[k] is the BCD scratch after k iterations; adj_s[k] is it after the add-3 pass.
  logic [BCD_W-1:0] bcd_s [0:WIDTH];
  logic [BCD_W-1:0] adj_s [0:WIDTH-1];
  logic [WIDTH-1:0] unused_msb_s;

  assign bcd_s[0] = {BCD_W{1'b0}};

  // Shifting only the BCD part while feeding in input bits MSB-first is the same as
  // shifting the whole zero-padded vector; the dropped top bit is always zero for <=999.
  for (genvar k = 0; k < WIDTH; k++) begin : g_iter
    for (genvar d = 0; d < BCD_DIGITS; d++) begin : g_digit
      bcd_add3 u_add3 (
        .digit_i (bcd_s[k][d*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .digit_o (adj_s[k][d*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
    assign bcd_s[k+1]      = {adj_s[k][BCD_W-2:0], signal[WIDTH-1-k]};
    assign unused_msb_s[k] = adj_s[k][BCD_W-1];
  end

  logic [BCD_DIGIT_W-1:0] hundred_d, tens_d, ones_d;
  logic [BCD_DIGIT_W-1:0] hundred_q, tens_q, ones_q;

`ifdef BCD_BLANK_LEADING_ZERO_EN
  // Leading-zero suppression: a zero hundreds digit blanks, and tens blanks only below 10.
  always_comb begin
    hundred_d = bcd_s[WIDTH][2*BCD_DIGIT_W +: BCD_DIGIT_W];
    tens_d    = bcd_s[WIDTH][BCD_DIGIT_W   +: BCD_DIGIT_W];
    ones_d    = bcd_s[WIDTH][0             +: BCD_DIGIT_W];
    if (hundred_d == 4'd0) begin
      hundred_d = BCD_BLANK;
      if (tens_d == 4'd0) begin
        tens_d = BCD_BLANK;
      end else begin
        tens_d = bcd_s[WIDTH][BCD_DIGIT_W +: BCD_DIGIT_W];
      end
    end else begin
      hundred_d = bcd_s[WIDTH][2*BCD_DIGIT_W +: BCD_DIGIT_W];
    end
  end
`else
  // Plain BCD digits straight from the dabble array.
  always_comb begin
    hundred_d = bcd_s[WIDTH][2*BCD_DIGIT_W +: BCD_DIGIT_W];
    tens_d    = bcd_s[WIDTH][BCD_DIGIT_W   +: BCD_DIGIT_W];
    ones_d    = bcd_s[WIDTH][0             +: BCD_DIGIT_W];
  end
`endif

  // Output register with asynchronous clear; reset value is zero in every configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hundred_q <= 4'd0;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
    end else begin
      hundred_q <= hundred_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
    end
  end

  assign hundred = hundred_q;
  assign tens    = tens_q;
  assign ones    = ones_q;

endmodule : binary_to_bcd

// File: tb/tb_binary_to_bcd.sv
// Directed self-checking bench for binary_to_bcd (WIDTH=9 when BCD_BLANK_LEADING_ZERO_EN is defined).
`timescale 1ns/1ps
module tb_binary_to_bcd;

`ifdef BCD_BLANK_LEADING_ZERO_EN
  localparam int WIDTH = 9;
`else
  localparam int WIDTH = 6;
`endif

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] signal;
  logic [3:0]       hundred, tens, ones;

  int n_tests;
  int n_fail;

  binary_to_bcd #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .signal  (signal),
    .hundred (hundred),
    .tens    (tens),
    .ones    (ones)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h %h %h, expected %h %h %h", tag,
               got[11:8], got[7:4], got[3:0], exp[11:8], exp[7:4], exp[3:0]);
    end
  endtask

  // Expected display digits for a value, including blanking when that build is selected.
  function automatic logic [11:0] exp_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
`ifdef BCD_BLANK_LEADING_ZERO_EN
    if (v < 100) h = 4'hF;
    if (v < 10)  t = 4'hF;
`endif
    return {h, t, o};
  endfunction

  function automatic logic [11:0] outs();
    return {hundred, tens, ones};
  endfunction

  task automatic apply_and_check(input string tag, input int v);
    @(negedge clk);
    signal = WIDTH'(v);
    @(posedge clk);
    #1;
    check_eq(tag, outs(), exp_bcd(v));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Reset with clocks running and signal=42.
    rst_n  = 1'b0;
    signal = WIDTH'(42);
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_hold", outs(), 12'h000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("reset_release_42", outs(), exp_bcd(42));

    // Sweep 0..59.
    for (int i = 0; i < 60; i++) begin
      apply_and_check($sformatf("sweep_%0d", i), i);
    end

    // Boundaries.
    apply_and_check("bound_0", 0);
    apply_and_check("bound_9", 9);
    apply_and_check("bound_10", 10);
    apply_and_check("bound_63", 63);

    // Asynchronous reset between edges, mid-sweep.
    apply_and_check("pre_reset_25", 25);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("async_clear", outs(), 12'h000);
    @(posedge clk);
    #1;
    check_eq("clear_held", outs(), 12'h000);
    signal = WIDTH'(26);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("resume_26", outs(), exp_bcd(26));

    // Latency: change right after an edge, outputs hold until the next one.
    apply_and_check("lat_8", 8);
    signal = WIDTH'(37);
    #3;
    check_eq("lat_hold_8", outs(), exp_bcd(8));
    @(posedge clk);
    #1;
    check_eq("lat_37", outs(), exp_bcd(37));

`ifdef BCD_BLANK_LEADING_ZERO_EN
    apply_and_check("blank_7", 7);
    check_eq("blank_7_lit", outs(), 12'hFF7);
    apply_and_check("blank_40", 40);
    check_eq("blank_40_lit", outs(), 12'hF40);
    apply_and_check("blank_305", 305);
    check_eq("blank_305_lit", outs(), 12'h305);
    apply_and_check("blank_0", 0);
    check_eq("blank_0_lit", outs(), 12'hFF0);
    apply_and_check("wide_100", 100);
    apply_and_check("wide_511", 511);
    check_eq("wide_511_lit", outs(), 12'h511);
`else
    apply_and_check("lit_59", 59);
    check_eq("lit_59_hex", outs(), 12'h059);
    apply_and_check("lit_0", 0);
    check_eq("lit_0_hex", outs(), 12'h000);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule : tb_binary_to_bcd
